accel_driver: RTL and testbench
===============================

# accel_driver

Initiator side of the start/ready accelerator handshake used by the system's small compute blocks. Accepts operand pairs from an upstream valid/ready request port, drives them with a one-cycle `start_o` pulse to an attached accelerator, and waits for the accelerator's `ready_i`. It then returns the captured result, or a timeout error, on a valid/ready response port. Saturating done/error counters are exposed for software-visible status.

## Interface
- `Width`, 32: operand and result width.
- `TimeoutCycles`, 16: maximum WAIT cycles before an error response. Legal range is 2..255.
- `CntWidth`, 16: width of the status counters.

- `clk` in 1: system clock; all state updates on its rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: upstream request valid.
- `req_ready_o` out 1: request accepted when high together with `req_valid_i`.
- `op0_i`, `op1_i` in Width: request operands.
- `start_o` out 1: one-cycle start pulse to the accelerator.
- `in0_o`, `in1_o` out Width: operands to the accelerator.
- `ready_i` in 1: accelerator completion.
- `result_i` in Width: accelerator result, valid while `ready_i` is high.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: downstream accepts the response.
- `rsp_data_o` out Width: result, or 0 on error.
- `rsp_err_o` out 1: response is a timeout.
- `busy_o` out 1: high in every state except IDLE.
- `done_cnt_o`, `err_cnt_o` out CntWidth: saturating completion and timeout counts.

## Operation
- FSM states and transitions:
  - IDLE: `req_ready_o`=1. On `req_valid_i`, capture `op0_i`/`op1_i` into the operand registers and go to ISSUE.
  - ISSUE: `start_o`=1 for exactly this one cycle; clear the wait counter; go to WAIT.
  - WAIT: `start_o`=0.
    - If `ready_i`=1: capture `result_i`, set err=0, increment `done_cnt_o`, go to RESP.
    - Else if the wait counter equals `TimeoutCycles`-1: set data=0, err=1, increment `err_cnt_o`, go to RESP.
    - Otherwise increment the wait counter.
  - RESP: `rsp_valid_o`=1, with data and err held stable. On `rsp_ready_i`, go to IDLE.
- `in0_o`/`in1_o` come straight from the operand registers and stay stable from ISSUE through RESP.
- Requests are strictly serialized: one outstanding transaction, and no new accept until the response is consumed.
- `ready_i` is ignored in IDLE, ISSUE and RESP. A late `ready_i` arriving after a timeout is dropped.
- `ready_i` and timeout in the same cycle: `ready_i` wins (normal completion, err=0).
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-transaction aborts it: FSM returns to IDLE and no response is produced.

## Timing
- Reset values: `req_ready_o`=1 (state IDLE). Every other output is 0: `start_o`, `in0_o`, `in1_o`, `rsp_valid_o`, `rsp_data_o`, `rsp_err_o`, `busy_o`, `done_cnt_o`, `err_cnt_o`.
- Transaction timeline (cycle 0 = accept cycle):
  - Cycle 0: request accepted in IDLE.
  - Cycle 1: `start_o` high.
  - Cycle 2 onward: `ready_i` sampled.
- A registered accelerator that raises ready one cycle after start gives `ready_i` in cycle 2 and `rsp_valid_o` in cycle 3. Minimum accept-to-response latency is therefore 3 cycles.
- Timeout: with no `ready_i`, `rsp_valid_o` with err rises in cycle `TimeoutCycles`+2.
- If `rsp_ready_i` is held high, RESP lasts one cycle and the next accept can occur in the following cycle. Maximum throughput is one transaction per 4 cycles.
- All outputs are registered or decoded from the state register only; there is no combinational path from any input to any output.

## Structure
- Package `accel_driver_pkg`:
  - `state_e` enum: IDLE, ISSUE, WAIT, RESP.
  - `TimeoutCntW` = 8.
- Sub-module `sat_cnt`: parameterised width, with increment enable and saturating behaviour. Instantiated twice, for the done and error counters.
- The FSM, operand/result registers and wait counter live in `accel_driver` itself.

## Test plan
- Nominal: accept op0=32'hF0F0_1234, op1=32'h0FF0_FFFF into a registered AND model → `start_o` pulses for exactly 1 cycle, `rsp_valid_o` rises at cycle 3, `rsp_data_o`=32'h00F0_1234, `rsp_err_o`=0, `done_cnt_o`=1.
- Timeout: accelerator never asserts ready, `TimeoutCycles`=16 → `rsp_valid_o` at cycle 18 with data=0 and err=1, `err_cnt_o`=1. A `ready_i` pulse injected at cycle 20 is ignored.
- Backpressure: `rsp_ready_i` low for 5 cycles → `rsp_data_o` is stable, `req_ready_o` stays 0, and a second `req_valid_i` is not accepted until the response handshake completes.
- Race: `ready_i` asserted in the final WAIT cycle (counter = 15) → err=0 and `done_cnt_o` increments, not `err_cnt_o`.
- Reset mid-WAIT: assert `rst_i` at cycle 2 → all outputs return to their reset values asynchronously and no `rsp_valid_o` follows. A new request after deassertion completes normally.
- Saturation: `CntWidth`=2 with 5 back-to-back successful transactions → `done_cnt_o` holds at 3.

Source files
------------

// File: rtl/accel_driver_pkg.sv
// Shared types and constants for the start/ready accelerator initiator.
package accel_driver_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    localparam int unsigned TimeoutCntW = 8;

endpackage

// File: rtl/accel_driver_if.sv
// Request, accelerator and response signals of accel_driver.
// master = the driver itself, slave = its environment.
interface accel_driver_if #(
    parameter int unsigned Width = 32
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [Width-1:0] op0_i;
    logic [Width-1:0] op1_i;
    logic             start_o;
    logic [Width-1:0] in0_o;
    logic [Width-1:0] in1_o;
    logic             ready_i;
    logic [Width-1:0] result_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [Width-1:0] rsp_data_o;
    logic             rsp_err_o;

    modport master (
        input  req_valid_i, op0_i, op1_i, ready_i, result_i, rsp_ready_i,
        output req_ready_o, start_o, in0_o, in1_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

    modport slave (
        output req_valid_i, op0_i, op1_i, ready_i, result_i, rsp_ready_i,
        input  req_ready_o, start_o, in0_o, in1_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );
endinterface

// File: rtl/accel_driver_sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/accel_driver.sv
// Initiator of the start/ready accelerator handshake: accept, pulse start,
// wait for ready or timeout, then hold the response until consumed.
module accel_driver
    import accel_driver_pkg::*;
#(
    parameter int unsigned Width         = 32,
    parameter int unsigned TimeoutCycles = 16,
    parameter int unsigned CntWidth      = 16
) (
    input  logic                clk,
    input  logic                rst_i,
    accel_driver_if.master      bus,
    output logic                busy_o,
    output logic [CntWidth-1:0] done_cnt_o,
    output logic [CntWidth-1:0] err_cnt_o
);

    localparam logic [TimeoutCntW-1:0] LastWait = TimeoutCntW'(TimeoutCycles - 1);

    state_e                 state_q, state_d;
    logic [Width-1:0]       op0_q, op1_q, data_q;
    logic                   err_q;
    logic [TimeoutCntW-1:0] wait_q;
    logic                   done_inc, err_inc;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ready_i is only looked at in WAIT and beats a coincident timeout.
    always_comb begin
        state_d  = state_q;
        done_inc = 1'b0;
        err_inc  = 1'b0;
        unique case (state_q)
            IDLE:  if (bus.req_valid_i) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.ready_i) begin
                    done_inc = 1'b1;
                    state_d  = RESP;
                end else if (wait_q == LastWait) begin
                    err_inc = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:  if (bus.rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_o = (state_q == IDLE);
        bus.start_o     = (state_q == ISSUE);
        bus.rsp_valid_o = (state_q == RESP);
        busy_o          = (state_q != IDLE);
        bus.in0_o       = op0_q;
        bus.in1_o       = op1_q;
        bus.rsp_data_o  = data_q;
        bus.rsp_err_o   = err_q;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            op0_q  <= '0;
            op1_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            wait_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        op0_q <= bus.op0_i;
                        op1_q <= bus.op1_i;
                    end
                end
                ISSUE: wait_q <= '0;
                WAIT: begin
                    if (done_inc) begin
                        data_q <= bus.result_i;
                        err_q  <= 1'b0;
                    end else if (err_inc) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    sat_cnt #(.Width(CntWidth)) u_done_cnt (
        .clk   (clk),
        .rst_i (rst_i),
        .inc_i (done_inc),
        .cnt_o (done_cnt_o)
    );

    sat_cnt #(.Width(CntWidth)) u_err_cnt (
        .clk   (clk),
        .rst_i (rst_i),
        .inc_i (err_inc),
        .cnt_o (err_cnt_o)
    );

endmodule

// File: tb/tb_accel_driver.sv
// Self-checking bench for accel_driver: vector table plus corner sequences,
// with a registered AND accelerator model and a response scoreboard.
module tb_accel_driver;

    localparam int W       = 32;
    localparam int TO      = 16;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    accel_driver_if #(.Width(W)) bus ();
    logic          busy;
    logic [CW-1:0] done_cnt, err_cnt;

    accel_driver #(.Width(W), .TimeoutCycles(TO), .CntWidth(CW)) dut (
        .clk        (clk),
        .rst_i      (rst),
        .bus        (bus),
        .busy_o     (busy),
        .done_cnt_o (done_cnt),
        .err_cnt_o  (err_cnt)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        logic [W-1:0] in0;
        logic [W-1:0] in1;
    } exp_t;

    typedef struct {
        logic [W-1:0] op0;
        logic [W-1:0] op1;
        int           delay;
        logic [W-1:0] data;
        logic         err;
        int           lat;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   exp_done = 0;
    int   exp_err  = 0;

    // Accelerator model: ready_i rises 'delay' cycles after start_o is seen.
    int acc_delay = 1;
    bit acc_on    = 1'b1;
    int acc_cnt   = 0;
    int inj_req   = 0;
    int inj_ack   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt = 0;
            bus.ready_i  <= 1'b0;
            bus.result_i <= '0;
        end else begin
            bus.ready_i <= 1'b0;
            if (bus.start_o && acc_on) acc_cnt = acc_delay;
            if (acc_cnt > 0) begin
                acc_cnt--;
                if (acc_cnt == 0) begin
                    bus.ready_i  <= 1'b1;
                    bus.result_i <= bus.in0_o & bus.in1_o;
                end
            end
            if (inj_req != inj_ack) begin
                inj_ack = inj_req;
                bus.ready_i  <= 1'b1;
                bus.result_i <= 32'hDEAD_BEEF;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready_o, 1);
        chk({tag, "_start"},     bus.start_o, 0);
        chk({tag, "_in0"},       bus.in0_o, 0);
        chk({tag, "_in1"},       bus.in1_o, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid_o, 0);
        chk({tag, "_rsp_data"},  bus.rsp_data_o, 0);
        chk({tag, "_rsp_err"},   bus.rsp_err_o, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_done_cnt"},  done_cnt, 0);
        chk({tag, "_err_cnt"},   err_cnt, 0);
    endtask

    // Called in a cycle where the DUT should be IDLE; returns in cycle 1.
    task automatic accept(input exp_t e);
        bus.op0_i       = e.in0;
        bus.op1_i       = e.in1;
        bus.req_valid_i = 1'b1;
        chk("accept_ready", bus.req_ready_o, 1);
        sb.push_back(e);
        tick();
        bus.req_valid_i = 1'b0;
        chk("start_pulse", bus.start_o, 1);
    endtask

    task automatic wait_rsp(input int exp_lat);
        int   n = 1;
        int   extra = 0;
        exp_t e;
        while (!bus.rsp_valid_o && n < 64) begin
            tick();
            n++;
            if (bus.start_o) extra++;
        end
        chk("start_once", extra, 0);
        if (!bus.rsp_valid_o || sb.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL rsp_wait: rsp_valid_o=%0b after %0d cycles, queue=%0d, required rsp by cycle %0d",
                     bus.rsp_valid_o, n, sb.size(), exp_lat);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            if (e.err) exp_err  = (exp_err  < CNT_MAX) ? exp_err + 1  : exp_err;
            else       exp_done = (exp_done < CNT_MAX) ? exp_done + 1 : exp_done;
            chk("rsp_latency", n, exp_lat);
            chk("rsp_data",    bus.rsp_data_o, e.data);
            chk("rsp_err",     bus.rsp_err_o, e.err);
            chk("in0_hold",    bus.in0_o, e.in0);
            chk("in1_hold",    bus.in1_o, e.in1);
            chk("done_cnt",    done_cnt, exp_done);
            chk("err_cnt",     err_cnt, exp_err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        exp_t e;
        int   seen;
        logic [W-1:0] a, b;

        tbl[0] = '{32'hF0F0_1234, 32'h0FF0_FFFF, 1,  32'h00F0_1234, 1'b0, 3};
        tbl[1] = '{32'hDEAD_BEEF, 32'h1234_5678, 0,  32'h0000_0000, 1'b1, TO + 2};
        tbl[2] = '{32'hA5A5_A5A5, 32'hFFFF_0000, TO, 32'hA5A5_0000, 1'b0, TO + 2};
        tbl[3] = '{32'hFFFF_FFFF, 32'h1234_5678, 3,  32'h1234_5678, 1'b0, 5};
        tbl[4] = '{32'h0F0F_0F0F, 32'h3333_3333, 15, 32'h0303_0303, 1'b0, 17};

        bus.req_valid_i = 1'b0;
        bus.op0_i       = '0;
        bus.op1_i       = '0;
        bus.rsp_ready_i = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            acc_on    = (tbl[i].delay != 0);
            acc_delay = tbl[i].delay;
            e = '{tbl[i].data, tbl[i].err, tbl[i].op0, tbl[i].op1};
            accept(e);
            wait_rsp(tbl[i].lat);
            tick();
            chk("idle_rsp_valid", bus.rsp_valid_o, 0);
            chk("idle_busy", busy, 0);
            if (tbl[i].err) begin
                // Late ready after a timeout must be dropped.
                inj_req++;
                tick();
                tick();
                chk("late_ready_busy", busy, 0);
                chk("late_ready_rsp", bus.rsp_valid_o, 0);
                chk("late_ready_done", done_cnt, exp_done);
                chk("late_ready_err", err_cnt, exp_err);
            end
        end

        // Backpressure: response held for 5 cycles while a new request waits.
        acc_on = 1'b1;
        acc_delay = 1;
        bus.rsp_ready_i = 1'b0;
        accept('{32'h1357_00DF, 1'b0, 32'h1357_9BDF, 32'hFFFF_00FF});
        wait_rsp(3);
        bus.op0_i       = 32'h89AB_CDEF;
        bus.op1_i       = 32'hF0F0_F0F0;
        bus.req_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_rsp_valid", bus.rsp_valid_o, 1);
            chk("bp_rsp_data", bus.rsp_data_o, 32'h1357_00DF);
            chk("bp_req_ready", bus.req_ready_o, 0);
            chk("bp_no_start", bus.start_o, 0);
        end
        bus.rsp_ready_i = 1'b1;
        tick();
        chk("bp_released", bus.rsp_valid_o, 0);
        accept('{32'h80A0_C0E0, 1'b0, 32'h89AB_CDEF, 32'hF0F0_F0F0});
        wait_rsp(3);
        tick();

        // Reset asserted in the first WAIT cycle.
        acc_delay = 5;
        accept('{32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        tick();
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        sb.delete();
        exp_done = 0;
        exp_err  = 0;
        tick();
        tick();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.rsp_valid_o) seen++;
        end
        chk("no_rsp_after_rst", seen, 0);

        acc_delay = 1;
        accept('{32'h0000_1234, 1'b0, 32'hF0F0_1234, 32'h0F0F_FFFF});
        wait_rsp(3);

        // Back-to-back transactions: accept every 4 cycles, done count saturates.
        for (int k = 0; k < 5; k++) begin
            tick();
            a = $urandom();
            b = $urandom();
            accept('{a & b, 1'b0, a, b});
            wait_rsp(3);
        end
        chk("sat_hold", done_cnt, CNT_MAX);
        chk("sat_err_clear", err_cnt, 0);
        tick();
        chk("final_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
